// File: rtl/cm162_count_sequencer_if.sv
// Host command channel for the count sequencer: valid/ready command handshake
// plus the completion report (done/aborted) returned to the host.
interface cm162_count_sequencer_if #(
    parameter int unsigned W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         done;
    logic         aborted;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  done,
        input  aborted
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output done,
        output aborted
    );
endinterface

// File: rtl/cm162_count_sequencer.sv
// Sequencer for NSLICE cascaded 4-bit load/count slices: owns the count register,
// runs LOAD/RUN host commands and drives the P/T enable chain across the slices.
module cm162_count_sequencer #(
    parameter int unsigned NSLICE = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    cm162_count_sequencer_if.slave cmd,
    input  logic                   en_p,
    input  logic                   en_t,
    input  logic                   abort,
    output logic [4*NSLICE-1:0]    count_q,
    output logic                   busy,
    output logic                   tc,
    output logic                   wrap_pulse
);
    localparam int unsigned W = 4 * NSLICE;

    localparam logic [1:0] OpLoad = 2'b01;
    localparam logic [1:0] OpRun  = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e         state_q;
    logic [W-1:0]   remaining_q;
    logic           end_by_abort_q;
    logic           done_q;
    logic           aborted_q;
    logic           wrap_q;

    logic           step;
    logic [NSLICE-1:0] slice_en;
    logic [W-1:0]   count_step;
    logic           carry_out;

    assign step = (state_q == StRun) & en_p & en_t & ~abort;

    // T-chain: a slice advances only when every slice below it sits at 4'hF.
    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        if (i == 0) begin : g_first
            assign slice_en[i] = step;
        end else begin : g_cascade
            assign slice_en[i] = slice_en[i-1] & (count_q[4*i-1 -: 4] == 4'hF);
        end
        assign count_step[4*i +: 4] = count_q[4*i +: 4] + {3'b000, slice_en[i]};
    end

    assign carry_out = slice_en[NSLICE-1] & (count_q[W-1 -: 4] == 4'hF);

    assign cmd.cmd_ready = (state_q == StIdle);
    assign cmd.done      = done_q;
    assign cmd.aborted   = aborted_q;
    assign busy          = (state_q != StIdle);
    assign tc            = en_t & (&count_q);
    assign wrap_pulse    = wrap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            count_q        <= '0;
            remaining_q    <= '0;
            end_by_abort_q <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            // Completion is reported in the cycle after the DONE state.
            done_q    <= (state_q == StDone);
            aborted_q <= (state_q == StDone) & end_by_abort_q;
            wrap_q    <= carry_out;

            case (state_q)
                StIdle: begin
                    if (cmd.cmd_valid) begin
                        if (cmd.cmd_op == OpLoad) begin
                            count_q        <= cmd.cmd_data;
                            end_by_abort_q <= 1'b0;
                            state_q        <= StDone;
                        end else if (cmd.cmd_op == OpRun) begin
                            end_by_abort_q <= 1'b0;
                            if (cmd.cmd_data == '0) begin
                                state_q <= StDone;
                            end else begin
                                remaining_q <= cmd.cmd_data;
                                state_q     <= StRun;
                            end
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        end_by_abort_q <= 1'b1;
                        state_q        <= StDone;
                    end else if (step) begin
                        count_q     <= count_step;
                        remaining_q <= remaining_q - W'(1);
                        if (remaining_q == W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cm162_count_sequencer.sv
// Self-checking bench for cm162_count_sequencer (NSLICE=2, W=8): directed scenarios
// plus random traffic compared against a cycle-level behavioural model.
module tb_cm162_count_sequencer;
    logic       clock;
    logic       reset_n;
    logic       en_p;
    logic       en_t;
    logic       abort;
    logic [7:0] count_q;
    logic       busy;
    logic       tc;
    logic       wrap_pulse;

    int errors;
    int checks;

    // Behavioural model: the counter is a plain integer mod 256.
    int m_count;
    int m_left;
    bit m_run;
    bit m_fin;
    bit m_abf;
    bit m_done;
    bit m_ab;
    bit m_wrap;

    cm162_count_sequencer_if #(.W(8)) cmd_if ();

    cm162_count_sequencer #(.NSLICE(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd        (cmd_if),
        .en_p       (en_p),
        .en_t       (en_t),
        .abort      (abort),
        .count_q    (count_q),
        .busy       (busy),
        .tc         (tc),
        .wrap_pulse (wrap_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_count = 0;
        m_left  = 0;
        m_run   = 0;
        m_fin   = 0;
        m_abf   = 0;
        m_done  = 0;
        m_ab    = 0;
        m_wrap  = 0;
    endtask

    // Advance the model with the current inputs, then move the DUT one clock.
    task automatic tick();
        int n_count;
        int n_left;
        bit n_run;
        bit n_fin;
        bit n_abf;
        bit n_wrap;
        n_count = m_count;
        n_left  = m_left;
        n_run   = m_run;
        n_fin   = 0;
        n_abf   = m_abf;
        n_wrap  = 0;
        if (!m_run && !m_fin) begin
            if (cmd_if.cmd_valid) begin
                if (cmd_if.cmd_op == 2'b01) begin
                    n_count = int'(cmd_if.cmd_data);
                    n_fin   = 1;
                    n_abf   = 0;
                end else if (cmd_if.cmd_op == 2'b10) begin
                    n_abf = 0;
                    if (cmd_if.cmd_data == 8'd0) n_fin = 1;
                    else begin
                        n_run  = 1;
                        n_left = int'(cmd_if.cmd_data);
                    end
                end
            end
        end else if (m_run) begin
            if (abort) begin
                n_run = 0;
                n_fin = 1;
                n_abf = 1;
            end else if (en_p && en_t) begin
                n_wrap  = (m_count == 255);
                n_count = (m_count + 1) % 256;
                n_left  = m_left - 1;
                if (n_left == 0) begin
                    n_run = 0;
                    n_fin = 1;
                end
            end
        end
        @(posedge clock);
        m_done  = m_fin;
        m_ab    = m_fin && m_abf;
        m_wrap  = n_wrap;
        m_count = n_count;
        m_left  = n_left;
        m_run   = n_run;
        m_fin   = n_fin;
        m_abf   = n_abf;
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_run || m_fin); i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en_t    = 1'b1;
        #3;
        model_reset();
        checks++;
        if ({count_q, busy, cmd_if.cmd_ready, cmd_if.done, cmd_if.aborted, wrap_pulse, tc}
            !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%h busy=%b ready=%b done=%b ab=%b wrap=%b tc=%b",
                     count_q, busy, cmd_if.cmd_ready, cmd_if.done, cmd_if.aborted,
                     wrap_pulse, tc, " required count=00 busy=0 ready=1 others=0");
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        issue(2'b01, 8'hA5);
        checks++;
        if (count_q !== 8'hA5 || busy !== 1'b1 || cmd_if.done !== 1'b0) begin
            errors++;
            $display("FAIL load_value: count=%h busy=%b done=%b required count=a5 busy=1 done=0",
                     count_q, busy, cmd_if.done);
        end
        tick();
        checks++;
        if (cmd_if.done !== 1'b1 || cmd_if.aborted !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: done=%b aborted=%b ready=%b required 1 0 1",
                     cmd_if.done, cmd_if.aborted, cmd_if.cmd_ready);
        end
        tick();
        checks++;
        if (cmd_if.done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_width: done=%b required 0", cmd_if.done);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        issue(2'b01, 8'hFD);
        tick();
        en_p = 1'b1;
        en_t = 1'b1;
        issue(2'b10, 8'd5);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (count_q !== exp_seq[k] || tc !== (exp_seq[k] == 8'hFF) ||
                wrap_pulse !== (exp_seq[k] == 8'h00) || cmd_if.done !== 1'b0) begin
                errors++;
                $display("FAIL wrap_step%0d: count=%h tc=%b wrap=%b done=%b required count=%h",
                         k, count_q, tc, wrap_pulse, cmd_if.done, exp_seq[k]);
            end
        end
        tick();
        checks++;
        if (cmd_if.done !== 1'b1 || count_q !== 8'h02 || wrap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: done=%b count=%h wrap=%b required 1 02 0",
                     cmd_if.done, count_q, wrap_pulse);
        end
    endtask

    task automatic test_toggle();
        int start;
        int busy_cycles;
        int dones;
        tick();
        start = m_count;
        en_p  = 1'b1;
        en_t  = 1'b1;
        issue(2'b10, 8'd4);
        busy_cycles = busy ? 1 : 0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            en_p = 1'(i % 2);
            tick();
            if (busy) busy_cycles++;
            if (cmd_if.done) dones++;
        end
        checks++;
        if (busy_cycles != 9 || dones != 1 || int'(count_q) != (start + 4) % 256) begin
            errors++;
            $display("FAIL toggle_run: busy_cycles=%0d dones=%0d count=%h required 9 1 %h",
                     busy_cycles, dones, count_q, 8'((start + 4) % 256));
        end
    endtask

    task automatic test_zero_and_t();
        en_p = 1'b1;
        en_t = 1'b1;
        issue(2'b01, 8'hFF);
        tick();
        issue(2'b10, 8'd0);
        checks++;
        if (busy !== 1'b1 || count_q !== 8'hFF || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_zero: busy=%b count=%h ready=%b required 1 ff 0",
                     busy, count_q, cmd_if.cmd_ready);
        end
        tick();
        checks++;
        if (cmd_if.done !== 1'b1 || count_q !== 8'hFF) begin
            errors++;
            $display("FAIL run_zero_done: done=%b count=%h required 1 ff", cmd_if.done, count_q);
        end
        en_t = 1'b0;
        issue(2'b10, 8'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count_q !== 8'hFF || tc !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL t_gated%0d: count=%h tc=%b busy=%b required ff 0 1",
                         i, count_q, tc, busy);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++;
        if (cmd_if.done !== 1'b1 || cmd_if.aborted !== 1'b1) begin
            errors++;
            $display("FAIL t_gated_abort: done=%b aborted=%b required 1 1",
                     cmd_if.done, cmd_if.aborted);
        end
        en_t = 1'b1;
    endtask

    task automatic test_abort();
        en_p = 1'b1;
        en_t = 1'b1;
        issue(2'b01, 8'h10);
        tick();
        issue(2'b10, 8'd10);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (count_q !== 8'h12 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold: count=%h busy=%b required 12 1", count_q, busy);
        end
        tick();
        checks++;
        if (cmd_if.done !== 1'b1 || cmd_if.aborted !== 1'b1 || count_q !== 8'h12) begin
            errors++;
            $display("FAIL abort_done: done=%b aborted=%b count=%h required 1 1 12",
                     cmd_if.done, cmd_if.aborted, count_q);
        end
    endtask

    task automatic test_reset_mid_run();
        en_p = 1'b1;
        en_t = 1'b1;
        issue(2'b01, 8'h30);
        tick();
        issue(2'b10, 8'd10);
        repeat (3) tick();
        checks++;
        if (count_q !== 8'h33) begin
            errors++;
            $display("FAIL pre_reset_count: count=%h required 33", count_q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count_q !== 8'h00 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 ||
            cmd_if.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: count=%h busy=%b ready=%b done=%b required 00 0 1 0",
                     count_q, busy, cmd_if.cmd_ready, cmd_if.done);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        checks++;
        if (cmd_if.done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: done=%b busy=%b required 0 0", cmd_if.done, busy);
        end
        issue(2'b00, 8'h77);
        tick();
        issue(2'b11, 8'h55);
        tick();
        checks++;
        if (count_q !== 8'h00 || busy !== 1'b0 || cmd_if.done !== 1'b0) begin
            errors++;
            $display("FAIL nop_ignored: count=%h busy=%b done=%b required 00 0 0",
                     count_q, busy, cmd_if.done);
        end
    endtask

    task automatic test_random();
        logic [13:0] obs;
        logic [13:0] exp;
        for (int i = 0; i < 600; i++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_op    = 2'($urandom_range(0, 3));
            cmd_if.cmd_data  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12))
                                                            : 8'($urandom);
            en_p  = ($urandom_range(0, 3) != 0);
            en_t  = ($urandom_range(0, 4) != 0);
            abort = ($urandom_range(0, 19) == 0);
            tick();
            obs = {count_q, busy, cmd_if.cmd_ready, tc, wrap_pulse, cmd_if.done,
                   cmd_if.aborted};
            exp = {8'(m_count), m_run | m_fin, !(m_run | m_fin), en_t && (m_count == 255),
                   m_wrap, m_done, m_ab};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d: {count,busy,ready,tc,wrap,done,ab}=%h required %h",
                         i, obs, exp);
            end
        end
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        drain();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        en_p = 1'b0;
        en_t = 1'b0;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 2'b00;
        cmd_if.cmd_data = 8'h00;
        model_reset();
        test_reset();
        test_load();
        test_wrap();
        test_toggle();
        test_zero_and_t();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
